// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate and register/opcode fields into an RV32I I/S/B/J instruction word.
// Two-stage valid/ready pipeline: S1 registers the fields and range-checks the immediate, S2 holds the assembled word.
module imm_encoder #(
    parameter int CNT_W   = 16,
    parameter bit ERR_NOP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_immSrc,
    input  logic [31:0]      in_imm,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } fmt_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        ready_q;
    logic        s1_valid;
    fmt_t        s1_src;
    logic [20:0] s1_imm;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_f3;
    logic        s1_err;

    logic        s2_free;
    logic        accept;
    logic        imm_err;
    logic [31:0] word;

    // S2 can take a new word when it is empty or its word leaves this cycle.
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = ready_q && (!s1_valid || s2_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        imm_err = 1'b0;
        case (fmt_t'(in_immSrc))
            FMT_I, FMT_S: imm_err = !((in_imm[31:11] == '0) || (in_imm[31:11] == '1));
            FMT_B:        imm_err = !((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) || in_imm[0];
            FMT_J:        imm_err = !((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) || in_imm[0];
            default:      imm_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_src   <= FMT_I;
            s1_imm   <= '0;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_f3    <= '0;
            s1_err   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_src <= fmt_t'(in_immSrc);
                s1_imm <= in_imm[20:0];
                s1_op  <= in_opcode;
                s1_rd  <= in_rd;
                s1_rs1 <= in_rs1;
                s1_rs2 <= in_rs2;
                s1_f3  <= in_funct3;
                s1_err <= imm_err;
            end
        end
    end

    always_comb begin
        word = '0;
        case (s1_src)
            FMT_I: word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
            FMT_S: word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
            FMT_B: word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                           s1_imm[4:1], s1_imm[11], s1_op};
            FMT_J: word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
            default: word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= (ERR_NOP && s1_err) ? NOP : word;
                out_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_valid && out_ready) begin
            enc_count <= enc_count + CNT_W'(1);
            if (out_err) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: three instances share stimulus (truncating, NOP-substituting, 4-bit counters).
// Outputs are captured on each transfer and compared against hand-computed words and a decode-path model.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_immSrc;
    logic [31:0] in_imm;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        out_ready;

    logic        rdy0, rdy1, rdy2;
    logic        o0_valid, o1_valid, o2_valid;
    logic [31:0] o0_instr, o1_instr, o2_instr;
    logic        o0_err, o1_err, o2_err;
    logic [15:0] o0_enc, o0_errc, o1_enc, o1_errc;
    logic [3:0]  o2_enc, o2_errc;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [31:0] i0;
        logic        e0;
        logic [31:0] i1;
        logic        e1;
        int          c;
    } rec_t;
    rec_t q[$];

    always #5 clk = ~clk;

    imm_encoder #(.CNT_W(16), .ERR_NOP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_immSrc(in_immSrc), .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .out_valid(o0_valid), .out_ready(out_ready), .out_instr(o0_instr), .out_err(o0_err),
        .enc_count(o0_enc), .err_count(o0_errc));

    imm_encoder #(.CNT_W(16), .ERR_NOP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_immSrc(in_immSrc), .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .out_valid(o1_valid), .out_ready(out_ready), .out_instr(o1_instr), .out_err(o1_err),
        .enc_count(o1_enc), .err_count(o1_errc));

    imm_encoder #(.CNT_W(4), .ERR_NOP(1'b0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
        .in_immSrc(in_immSrc), .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .out_valid(o2_valid), .out_ready(out_ready), .out_instr(o2_instr), .out_err(o2_err),
        .enc_count(o2_enc), .err_count(o2_errc));

    always @(posedge clk) begin
        if (in_valid) begin
            assert (!$isunknown(in_immSrc)) else $error("in_immSrc is x/z while in_valid is high");
        end
    end

    always @(posedge clk) begin
        if (!reset && o0_valid && out_ready) begin
            q.push_back('{o0_instr, o0_err, o1_instr, o1_err, cyc});
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] i);
        case (src)
            2'b00:   return {{20{i[31]}}, i[31:20]};
            2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [1:0] src, input logic [31:0] imm, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3);
        int n;
        in_immSrc = src; in_imm = imm; in_opcode = op;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3;
        in_valid = 1'b1;
        n = 0;
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) chk("in_ready_timeout", 32'(rdy0), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_out(output rec_t r);
        int n;
        n = 0;
        while (q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() == 0) begin
            chk("out_timeout", 32'(q.size()), 32'd1);
            r = '{32'h0, 1'b0, 32'h0, 1'b0, 0};
        end else begin
            r = q.pop_front();
        end
    endtask

    task automatic run1(input string tag, input logic [1:0] src, input logic [31:0] imm,
                        input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] exp_instr, input logic exp_err);
        rec_t r;
        push(src, imm, op, rd, rs1, rs2, f3);
        get_out(r);
        chk({tag, "_instr"}, r.i0, exp_instr);
        chk({tag, "_err"}, 32'(r.e0), 32'(exp_err));
    endtask

    initial begin
        rec_t r, ra, rb, rc;
        logic [31:0] imm;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_immSrc = '0; in_imm = '0; in_opcode = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;

        #2;
        chk("rst_out_valid", 32'(o0_valid), 32'd0);
        chk("rst_out_instr", o0_instr, 32'd0);
        chk("rst_out_err",   32'(o0_err), 32'd0);
        chk("rst_enc_count", 32'(o0_enc), 32'd0);
        chk("rst_err_count", 32'(o0_errc), 32'd0);
        chk("rst_in_ready",  32'(rdy0), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("in_ready_before_edge", 32'(rdy0), 32'd0);
        @(negedge clk);
        chk("in_ready_after_edge", 32'(rdy0), 32'd1);

        // I-format with latency checks
        push(2'b00, 32'hFFFF_FFFF, 7'h13, 5'd5, 5'd6, 5'd31, 3'd0);
        chk("lat_s1_empty_out", 32'(o0_valid), 32'd0);
        @(negedge clk);
        chk("lat_out_valid", 32'(o0_valid), 32'd1);
        get_out(r);
        chk("i_instr", r.i0, 32'hFFF3_0293);
        chk("i_err",   32'(r.e0), 32'd0);
        chk("i_enc_count", 32'(o0_enc), 32'd1);

        run1("s", 2'b01, 32'd8, 7'h23, 5'd31, 5'd2, 5'd7, 3'd2, 32'h0071_2423, 1'b0);
        run1("b", 2'b10, 32'hFFFF_FFFC, 7'h63, 5'd31, 5'd1, 5'd2, 3'd0, 32'hFE20_8EE3, 1'b0);
        run1("j", 2'b11, 32'd2048, 7'h6F, 5'd1, 5'd3, 5'd4, 3'd5, 32'h0010_00EF, 1'b0);

        run1("i_err", 2'b00, 32'd2048, 7'h13, 5'd0, 5'd0, 5'd9, 3'd0, 32'h8000_0013, 1'b1);
        chk("i_err_count", 32'(o0_errc), 32'd1);
        run1("b_odd", 2'b10, 32'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0020_8163, 1'b1);

        push(2'b11, 32'h0010_0000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
        get_out(r);
        chk("j_err_trunc_instr", r.i0, 32'h8000_00EF);
        chk("j_err_nop_instr", r.i1, 32'h0000_0013);
        chk("j_err_nop_err", 32'(r.e1), 32'd1);
        chk("j_err_enc_count", 32'(o0_enc), 32'd7);
        chk("j_err_err_count", 32'(o0_errc), 32'd3);

        // Legal-immediate sweep, checked by round trip through the decode path
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) begin
                case (f)
                    0, 1:    imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                    2:       imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                    default: imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
                endcase
                push(2'(f), imm, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
                get_out(r);
                chk($sformatf("rt_f%0d_k%0d", f, k), decode(2'(f), r.i0), imm);
                chk($sformatf("rt_err_f%0d_k%0d", f, k), 32'(r.e0), 32'd0);
            end
        end

        // Backpressure: two held, third stalls until the consumer releases
        reset = 1'b1; #1; reset = 1'b0;
        @(negedge clk);
        q.delete();
        out_ready = 1'b0;
        push(2'b00, 32'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        push(2'b00, 32'd2, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        fork
            push(2'b00, 32'd3, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
            begin
                chk("bp_in_ready_low", 32'(rdy0), 32'd0);
                repeat (2) @(negedge clk);
                chk("bp_in_ready_still_low", 32'(rdy0), 32'd0);
                @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        get_out(ra);
        get_out(rb);
        get_out(rc);
        chk("bp_word0", ra.i0, 32'h0010_0093);
        chk("bp_word1", rb.i0, 32'h0020_0093);
        chk("bp_word2", rc.i0, 32'h0030_0093);
        chk("bp_gap01", 32'(rb.c - ra.c), 32'd1);
        chk("bp_gap12", 32'(rc.c - rb.c), 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_no_dup", 32'(q.size()), 32'd0);
        chk("bp_enc_count", 32'(o0_enc), 32'd3);

        // Asynchronous reset with two instructions in flight
        out_ready = 1'b0;
        push(2'b00, 32'd4, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        push(2'b00, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(o0_valid), 32'd0);
        chk("mid_rst_enc_count", 32'(o0_enc), 32'd0);
        chk("mid_rst_err_count", 32'(o0_errc), 32'd0);
        chk("mid_rst_enc4", 32'(o2_enc), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        push(2'b00, 32'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        chk("post_rst_lat_s1", 32'(o0_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_lat_out", 32'(o0_valid), 32'd1);
        get_out(r);
        chk("post_rst_instr", r.i0, 32'h0060_0093);
        chk("post_rst_enc_count", 32'(o0_enc), 32'd1);

        // 4-bit counter wrap after 17 transfers
        reset = 1'b1; #1; reset = 1'b0;
        @(negedge clk);
        q.delete();
        for (int k = 0; k < 17; k++) begin
            push(2'b01, 32'(k), 7'h23, 5'd0, 5'd1, 5'd2, 3'd2);
        end
        for (int k = 0; k < 17; k++) begin
            get_out(r);
            chk($sformatf("wrap_seq_%0d", k), decode(2'b01, r.i0), 32'(k));
        end
        chk("wrap_enc4", 32'(o2_enc), 32'd1);
        chk("wrap_enc16", 32'(o0_enc), 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate sign-extension decode path: packs a 32-bit immediate plus register/opcode fields into a RISC-V RV32I instruction word for I-, S-, B- or J-format.
- Used by the self-test instruction generator and by the instruction-memory loader.
- 2-stage pipeline with valid/ready handshakes on both sides.
- Range-checks each immediate and keeps encoded/error counters.

Parameters:
- CNT_W, 16, width of the enc_count and err_count counters.
- ERR_NOP, 0, if 1 an errored instruction is replaced by the NOP 32'h00000013; if 0 it carries the truncated encoding.

Ports:
- clk  input  1  the single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept.
- in_immSrc  input  2  format select: 00 I, 01 S, 10 B, 11 J (same coding as the decode path).
- in_imm  input  32  signed byte-offset immediate.
- in_opcode  input  7  opcode field.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3 field.
- out_valid  output  1  instruction valid.
- out_ready  input  1  consumer accepts.
- out_instr  output  32  encoded instruction.
- out_err  output  1  immediate out of range or misaligned for this instruction.
- enc_count  output  CNT_W  instructions delivered (out_valid & out_ready), wraps.
- err_count  output  CNT_W  delivered instructions with out_err=1, wraps.

Behaviour:
- Reset (asynchronous, immediate): both stage valids = 0; out_valid = 0, out_instr = 0, out_err = 0, enc_count = 0, err_count = 0. in_ready = 1 from the first clock edge after reset deasserts.
- Handshake: a transfer occurs on a rising edge with valid & ready both high.
- Inputs and outputs are stable while valid is high and ready is low; in_ready never depends combinationally on in_valid.
- Stage 1 (S1):
  - Registers the fields and computes err.
  - I/S: err when in_imm[31:11] is not all-equal (range -2048..2047).
  - B: err when in_imm[31:12] is not all-equal or in_imm[0]=1 (range -4096..4094, even).
  - J: err when in_imm[31:20] is not all-equal or in_imm[0]=1 (range -1048576..1048574, even).
- Stage 2 (S2, output register) assembles the word:
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=f3, [11:7]=rd, [6:0]=opcode; rs2 is ignored.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=f3, [11:7]=imm[4:0]; rd is ignored.
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=f3, [11:8]=imm[4:1], [7]=imm[11]; imm[0] is dropped.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd; rs1/rs2/f3 are ignored.
- Errored words: with ERR_NOP=1 the word is 32'h00000013 and out_err=1; with ERR_NOP=0 the truncated encoding above is output with out_err=1.
- Latency and throughput: exactly 2 cycles from input acceptance to out_valid with no backpressure; 1 instruction per cycle sustained.
- Backpressure:
  - Each stage advances when the downstream stage is empty or transferring.
  - in_ready = !S1_valid | S1_advance.
  - Up to 2 instructions are held; none are lost, duplicated or reordered.
- Counters increment on output transfer only and wrap modulo 2^CNT_W. err_count increments in the same cycle as enc_count when out_err=1.
- Round-trip property: for out_err=0, decoding out_instr with the same immSrc through the decode-path extender returns in_imm exactly.
- Unknown (x/z) immSrc: not supported. A bench assertion fires when in_valid=1 with an x/z in_immSrc.
- Reset mid-operation: all in-flight instructions are discarded, no partial output appears, and counters clear.

Test Plan:
- I-format: immSrc=00, opcode=0x13, rd=5, rs1=6, f3=0, imm=-1 -> after 2 cycles out_instr=0xFFF30293, out_err=0, enc_count=1.
- S-format: immSrc=01, opcode=0x23, rs1=2, rs2=7, f3=2, imm=8 -> out_instr=0x00712423. B-format: immSrc=10, opcode=0x63, rs1=1, rs2=2, f3=0, imm=-4 -> out_instr=0xFE208EE3.
- J-format: immSrc=11, opcode=0x6F, rd=1, imm=2048 -> out_instr=0x001000EF. Random sweep of legal immediates for all four formats -> round-trip through the decoder equals in_imm.
- Errors:
  - ERR_NOP=0, I-format, opcode=0x13, rd=rs1=0, imm=2048 -> out_instr=0x80000013, out_err=1, err_count=1.
  - B-format with imm=3 -> out_err=1.
  - ERR_NOP=1, J-format with imm=0x100000 -> out_instr=0x00000013, out_err=1.
- Backpressure: out_ready=0 for 4 cycles while driving 3 back-to-back valid inputs -> in_ready drops after 2 are accepted; releasing out_ready yields the 3 words in order with no gaps or duplicates, enc_count=3.
- Reset asserted asynchronously mid-cycle with 2 instructions in flight -> out_valid=0 and both counters=0 immediately; first post-reset input emerges 2 cycles after acceptance. CNT_W=4 with 17 transfers -> enc_count=1.
